// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds FSM encoding, bus widths and the jump/stall polarities.
package if_fetch_pkg;

    localparam int ADDR_W  = 32;
    localparam int INST_W  = 32;
    localparam int STALL_W = 2;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INST_W-1:0]  inst_t;
    typedef logic [STALL_W-1:0] stall_t;

    localparam logic JUMP     = 1'b1;
    localparam logic NO_JUMP  = 1'b0;
    localparam logic STALL    = 1'b1;
    localparam logic NO_STALL = 1'b0;

    // Bit positions inside the stall vector.
    localparam int STALL_PC   = 0;
    localparam int STALL_IFID = 1;

    localparam addr_t ZERO32 = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OFFER = 2'd2
    } state_e;

endpackage

// File: rtl/if_fetch_if.sv
// Pipeline, redirect and byte-memory signals of the fetch stage.
// master = fetch unit, slave = surrounding pipeline/memory controller.
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic       rdy_in;
    stall_t     stall_in;
    logic       pcJump_in;
    addr_t      pcTarget_in;
    logic       memRe_out;
    addr_t      memAddr_out;
    logic       memGrant_in;
    logic [7:0] memByte_in;
    logic       stallReq_out;
    logic       instE_out;
    addr_t      pc_out;
    inst_t      inst_out;

    modport master (
        input  rdy_in, stall_in, pcJump_in, pcTarget_in, memGrant_in, memByte_in,
        output memRe_out, memAddr_out, stallReq_out, instE_out, pc_out, inst_out
    );

    modport slave (
        output rdy_in, stall_in, pcJump_in, pcTarget_in, memGrant_in, memByte_in,
        input  memRe_out, memAddr_out, stallReq_out, instE_out, pc_out, inst_out
    );

endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache: combinational lookup, synchronous fill,
// valid bits cleared asynchronously by reset.
module icache
    import if_fetch_pkg::*;
#(
    parameter int LINES = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    input  addr_t addr_i,
    output logic  hit_o,
    output inst_t data_o,
    input  logic  we_i,
    input  inst_t wdata_i
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem [LINES];
    inst_t            data_mem [LINES];

    assign idx    = addr_i[IDX_W+1:2];
    assign tag    = addr_i[ADDR_W-1:IDX_W+2];
    assign hit_o  = valid_q[idx] && (tag_mem[idx] == tag);
    assign data_o = data_mem[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[idx] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays carry no reset; a clear valid bit already masks their contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= wdata_i;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: icache lookup, byte-serial miss refill from memory,
// and a held offer to IF_ID until the pipeline accepts it.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter addr_t RESET_PC     = 32'h0,
    parameter int    ICACHE_LINES = 32
) (
    input  logic       clk_in,
    input  logic       rst_in,
    if_fetch_if.master bus
);

    state_e     state_q;
    addr_t      pc_q;
    logic [1:0] issue_cnt_q;
    logic [1:0] recv_cnt_q;
    logic       byte_pend_q;
    inst_t      word_q;
    logic       mem_re_q;
    addr_t      mem_addr_q;
    logic       stall_req_q;
    logic       inst_e_q;
    addr_t      pc_out_q;
    inst_t      inst_out_q;

    logic  jump;
    logic  grant;
    logic  fill_done;
    logic  hit;
    inst_t hit_word;
    inst_t fill_word;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        fill_word = word_q;
        fill_word[{recv_cnt_q, 3'b000} +: 8] = bus.memByte_in;
    end

    assign jump      = (bus.pcJump_in == JUMP);
    assign grant     = mem_re_q && bus.memGrant_in;
    assign fill_done = bus.rdy_in && !jump && (state_q == FETCH)
                       && byte_pend_q && (recv_cnt_q == 2'd3);

    icache #(.LINES(ICACHE_LINES)) u_icache (
        .clk     (clk_in),
        .rst_n   (rst_in),
        .addr_i  (pc_q),
        .hit_o   (hit),
        .data_o  (hit_word),
        .we_i    (fill_done),
        .wdata_i (fill_word)
    );

    // NOTE: state registers use <= so every branch sees the pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            byte_pend_q <= 1'b0;
            word_q      <= ZERO32;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= ZERO32;
            stall_req_q <= 1'b0;
            inst_e_q    <= 1'b0;
            pc_out_q    <= ZERO32;
            inst_out_q  <= ZERO32;
        end else if (bus.rdy_in) begin
            if (jump) begin
                pc_q        <= bus.pcTarget_in;
                state_q     <= IDLE;
                issue_cnt_q <= '0;
                recv_cnt_q  <= '0;
                byte_pend_q <= 1'b0;
                mem_re_q    <= 1'b0;
                stall_req_q <= 1'b0;
                inst_e_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.stall_in[STALL_PC] == NO_STALL) begin
                            if (hit) begin
                                state_q    <= OFFER;
                                inst_e_q   <= 1'b1;
                                pc_out_q   <= pc_q;
                                inst_out_q <= hit_word;
                            end else begin
                                state_q     <= FETCH;
                                mem_re_q    <= 1'b1;
                                mem_addr_q  <= pc_q;
                                stall_req_q <= 1'b1;
                                issue_cnt_q <= '0;
                                recv_cnt_q  <= '0;
                                byte_pend_q <= 1'b0;
                            end
                        end
                    end
                    FETCH: begin
                        // A byte is due on memByte_in exactly one cycle after each grant.
                        byte_pend_q <= grant;
                        if (grant) begin
                            issue_cnt_q <= issue_cnt_q + 2'd1;
                            if (issue_cnt_q == 2'd3) begin
                                mem_re_q <= 1'b0;
                            end else begin
                                mem_addr_q <= pc_q + 32'(issue_cnt_q) + 32'd1;
                            end
                        end
                        if (byte_pend_q) begin
                            word_q     <= fill_word;
                            recv_cnt_q <= recv_cnt_q + 2'd1;
                            if (recv_cnt_q == 2'd3) begin
                                state_q     <= OFFER;
                                stall_req_q <= 1'b0;
                                inst_e_q    <= 1'b1;
                                pc_out_q    <= pc_q;
                                inst_out_q  <= fill_word;
                            end
                        end
                    end
                    OFFER: begin
                        if (bus.stall_in[STALL_IFID] == NO_STALL) begin
                            pc_q     <= pc_q + 32'd4;
                            state_q  <= IDLE;
                            inst_e_q <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.memRe_out    = mem_re_q && bus.rdy_in;
    assign bus.memAddr_out  = mem_addr_q;
    assign bus.stallReq_out = stall_req_q;
    assign bus.instE_out    = inst_e_q;
    assign bus.pc_out       = pc_out_q;
    assign bus.inst_out     = inst_out_q;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed instruction words.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam addr_t RESET_PC = 32'h0;
    localparam int    LINES    = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    if_fetch_if bus ();

    if_fetch #(.RESET_PC(RESET_PC), .ICACHE_LINES(LINES)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory image: first word is the cold-fetch program, elsewhere byte = addr[7:0] + 0x11.
    function automatic logic [7:0] mem_byte(input addr_t a);
        case (a)
            32'h0:   return 8'h13;
            32'h1:   return 8'h05;
            32'h2:   return 8'hA0;
            32'h3:   return 8'h00;
            default: return a[7:0] + 8'h11;
        endcase
    endfunction

    function automatic inst_t mem_word(input addr_t a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    // Memory responder: returns the byte one cycle after each grant.
    logic [7:0] next_byte = 8'h00;
    addr_t      grant_q[$];
    int         re_cnt = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.memRe_out) re_cnt++;
            if (bus.memRe_out && bus.memGrant_in) begin
                next_byte = mem_byte(bus.memAddr_out);
                grant_q.push_back(bus.memAddr_out);
            end
        end
    end

    always @(negedge clk) bus.memByte_in = next_byte;

    function automatic addr_t first_grant();
        return (grant_q.size() > 0) ? grant_q[0] : 32'hDEADBEEF;
    endfunction

    // Behavioural model: a fetch is a count of granted and returned bytes;
    // the cache remembers full word addresses per line.
    typedef enum {M_IDLE, M_FETCH, M_OFFER} mphase_e;
    mphase_e     m_phase;
    addr_t       m_pc;
    int          m_issued;
    int          m_got;
    bit          m_pend;
    bit          m_granted;
    inst_t       m_word;
    bit          c_val  [LINES];
    logic [29:0] c_line [LINES];
    inst_t       c_word [LINES];

    function automatic int line_of(input addr_t a);
        return int'((a >> 2) % LINES);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  = M_IDLE;
            m_pc     = RESET_PC;
            m_issued = 0;
            m_got    = 0;
            m_pend   = 0;
            m_word   = '0;
            foreach (c_val[i]) c_val[i] = 0;
        end else if (bus.rdy_in) begin
            if (bus.pcJump_in) begin
                m_pc     = bus.pcTarget_in;
                m_phase  = M_IDLE;
                m_issued = 0;
                m_got    = 0;
                m_pend   = 0;
            end else begin
                case (m_phase)
                    M_IDLE: if (!bus.stall_in[0]) begin
                        if (c_val[line_of(m_pc)] && c_line[line_of(m_pc)] == m_pc[31:2]) begin
                            m_word  = c_word[line_of(m_pc)];
                            m_phase = M_OFFER;
                        end else begin
                            m_phase  = M_FETCH;
                            m_issued = 0;
                            m_got    = 0;
                            m_pend   = 0;
                        end
                    end
                    M_FETCH: begin
                        m_granted = (m_issued < 4) && bus.memGrant_in;
                        if (m_pend) m_got++;
                        m_pend = m_granted;
                        if (m_granted) m_issued++;
                        if (m_got == 4) begin
                            c_val[line_of(m_pc)]  = 1;
                            c_line[line_of(m_pc)] = m_pc[31:2];
                            c_word[line_of(m_pc)] = mem_word(m_pc);
                            m_word  = mem_word(m_pc);
                            m_phase = M_OFFER;
                        end
                    end
                    M_OFFER: if (!bus.stall_in[1]) begin
                        m_pc    = m_pc + 32'd4;
                        m_phase = M_IDLE;
                    end
                    default: m_phase = M_IDLE;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            check("cyc_memRe", bus.memRe_out,
                  (m_phase == M_FETCH) && (m_issued < 4) && bus.rdy_in);
            check("cyc_stallReq", bus.stallReq_out, m_phase == M_FETCH);
            check("cyc_instE", bus.instE_out, m_phase == M_OFFER);
            if (m_phase == M_FETCH && m_issued < 4)
                check("cyc_memAddr", bus.memAddr_out, m_pc + addr_t'(m_issued));
            if (m_phase == M_OFFER) begin
                check("cyc_pc_out", bus.pc_out, m_pc);
                check("cyc_inst_out", bus.inst_out, m_word);
            end
        end
    end

    task automatic wait_inst_e(input string name);
        int n = 0;
        while (!bus.instE_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_instE_timeout"}, bus.instE_out, 1'b1);
    endtask

    task automatic wait_stall_req(input string name);
        int n = 0;
        while (!bus.stallReq_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_stallReq_timeout"}, bus.stallReq_out, 1'b1);
    endtask

    task automatic do_jump(input addr_t tgt);
        bus.pcJump_in   = 1'b1;
        bus.pcTarget_in = tgt;
        @(negedge clk);
        bus.pcJump_in   = 1'b0;
    endtask

    task automatic release_offer();
        bus.stall_in = 2'b00;
        @(negedge clk);
        bus.stall_in = 2'b10;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_memRe"},    bus.memRe_out,    1'b0);
        check({name, "_memAddr"},  bus.memAddr_out,  32'h0);
        check({name, "_stallReq"}, bus.stallReq_out, 1'b0);
        check({name, "_instE"},    bus.instE_out,    1'b0);
        check({name, "_pc_out"},   bus.pc_out,       32'h0);
        check({name, "_inst_out"}, bus.inst_out,     32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int r0;
        bus.rdy_in      = 1'b1;
        bus.stall_in    = 2'b10;
        bus.pcJump_in   = 1'b0;
        bus.pcTarget_in = 32'h0;
        bus.memGrant_in = 1'b1;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        grant_q.delete();
        rst_n = 1'b1;

        // Cold fetch from RESET_PC.
        wait_inst_e("cold");
        check("cold_inst", bus.inst_out, 32'h00A00513);
        check("cold_pc", bus.pc_out, 32'h0);
        check("cold_grants", grant_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("cold_addr%0d", i),
                  (grant_q.size() > i) ? grant_q[i] : 32'hDEADBEEF, i);

        // Offer held for 3 cycles, then PC advances to 4.
        repeat (3) @(negedge clk);
        check("hold_instE", bus.instE_out, 1'b1);
        check("hold_pc", bus.pc_out, 32'h0);
        check("hold_inst", bus.inst_out, 32'h00A00513);
        grant_q.delete();
        release_offer();
        wait_inst_e("adv");
        check("adv_first_addr", first_grant(), 32'h4);
        check("adv_pc", bus.pc_out, 32'h4);
        check("adv_inst", bus.inst_out, 32'h18171615);

        // Grant withheld for two cycles after the first byte.
        do_jump(32'h60);
        wait_stall_req("gstall");
        @(negedge clk);
        bus.memGrant_in = 1'b0;
        check("gstall_addr_a", bus.memAddr_out, 32'h61);
        @(negedge clk);
        check("gstall_addr_b", bus.memAddr_out, 32'h61);
        check("gstall_stallReq", bus.stallReq_out, 1'b1);
        @(negedge clk);
        bus.memGrant_in = 1'b1;
        wait_inst_e("gstall");
        check("gstall_inst", bus.inst_out, 32'h74737271);
        check("gstall_pc", bus.pc_out, 32'h60);

        // Re-jump to 0: cache hit, no memory traffic.
        do_jump(32'h0);
        r0 = re_cnt;
        check("hit_idle_instE", bus.instE_out, 1'b0);
        @(negedge clk);
        check("hit_instE", bus.instE_out, 1'b1);
        check("hit_inst", bus.inst_out, 32'h00A00513);
        check("hit_no_memRe", re_cnt, r0);

        // Jump after two grants: stale bytes dropped, fetch restarts at target.
        do_jump(32'h40);
        wait_stall_req("abort");
        repeat (2) @(negedge clk);
        do_jump(32'h100);
        grant_q.delete();
        wait_inst_e("redir");
        check("redir_addr", first_grant(), 32'h100);
        check("redir_inst", bus.inst_out, 32'h14131211);
        check("redir_pc", bus.pc_out, 32'h100);

        // Aborted fetch left 0x40 uncached; freeze mid-fetch; jump on the last byte.
        bus.memGrant_in = 1'b0;
        do_jump(32'h40);
        wait_stall_req("refill");
        check("refill_memRe", bus.memRe_out, 1'b1);
        check("refill_addr", bus.memAddr_out, 32'h40);
        bus.rdy_in = 1'b0;
        @(negedge clk);
        check("frozen_memRe", bus.memRe_out, 1'b0);
        check("frozen_stallReq", bus.stallReq_out, 1'b1);
        check("frozen_addr", bus.memAddr_out, 32'h40);
        @(negedge clk);
        bus.rdy_in      = 1'b1;
        bus.memGrant_in = 1'b1;
        repeat (4) @(negedge clk);
        do_jump(32'h60);
        check("lastbyte_jump_instE", bus.instE_out, 1'b0);
        @(negedge clk);
        check("lastbyte_hit_instE", bus.instE_out, 1'b1);
        check("lastbyte_hit_pc", bus.pc_out, 32'h60);
        do_jump(32'h40);
        wait_stall_req("lastbyte_nofill");
        wait_inst_e("refill2");
        check("refill2_inst", bus.inst_out, 32'h54535251);

        // PC wrap from 0xFFFFFFFC to 0.
        do_jump(32'hFFFFFFFC);
        wait_inst_e("wrap");
        check("wrap_inst", bus.inst_out, 32'h100F0E0D);
        check("wrap_pc", bus.pc_out, 32'hFFFFFFFC);
        grant_q.delete();
        release_offer();
        wait_inst_e("wrapped");
        check("wrapped_pc", bus.pc_out, 32'h0);
        check("wrapped_inst", bus.inst_out, 32'h00A00513);
        check("wrapped_addr", first_grant(), 32'h0);

        // Asynchronous reset in the middle of a fetch.
        do_jump(32'hC0);
        wait_stall_req("midrst");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        grant_q.delete();
        rst_n = 1'b1;
        wait_inst_e("postrst");
        check("postrst_pc", bus.pc_out, RESET_PC);
        check("postrst_inst", bus.inst_out, 32'h00A00513);
        check("postrst_addr", first_grant(), RESET_PC);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0, giving the PC loaded on reset.
REQ-002 The block SHALL have parameter ICACHE_LINES, default 32, giving the direct-mapped icache depth (power of two).
REQ-003 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  asynchronous active-low reset.
REQ-005 rdy_in  input  1  global enable; 0 freezes all state.
REQ-006 stall_in  input  `stallRange  pipeline stall vector; bit0 = PC/IF stall, bit1 = IF_ID stall.
REQ-007 pcJump_in  input  1  redirect request from EX (`Jump).
REQ-008 pcTarget_in  input  `addrRange  redirect target PC.
REQ-009 memRe_out  input-to-controller: output  1  byte read request.
REQ-010 memAddr_out  output  `addrRange  byte address of the request.
REQ-011 memGrant_in  input  1  controller issued this cycle's request to RAM.
REQ-012 memByte_in  input  8  read data, valid the cycle after a granted request.
REQ-013 stallReq_out  output  1  IF requests pipeline stall while fetching from memory.
REQ-014 instE_out  output  1  pc_out/inst_out hold a valid instruction for IF_ID.
REQ-015 pc_out  output  `addrRange  PC of offered instruction.
REQ-016 inst_out  output  `instRange  offered instruction word.

Function
REQ-017 The block SHALL use FSM states IDLE, FETCH, OFFER.
REQ-018 In IDLE with stall_in[0]==`NoStall, the block SHALL look up pc in the icache; hit -> OFFER next cycle with cached word; miss -> FETCH.
REQ-019 In FETCH the block SHALL assert memRe_out with memAddr_out = pc + issue_cnt, issue_cnt 0..3, incrementing only on cycles with memGrant_in==1.
REQ-020 If memGrant_in==0, memAddr_out SHALL hold unchanged and retry next cycle.
REQ-021 The byte on memByte_in the cycle after grant k SHALL be written to inst bits [8k+7:8k] (little-endian); a recv counter tracks returned bytes.
REQ-022 After the 4th byte returns, the block SHALL write {tag, word, valid} to the icache and enter OFFER on the next edge (miss latency: 5 cycles minimum from FETCH entry).
REQ-023 stallReq_out SHALL be 1 exactly while state==FETCH.
REQ-024 In OFFER, instE_out SHALL be 1 with pc_out/inst_out stable until a cycle with stall_in[1]==`NoStall; at that edge pc <= pc+4 and state -> IDLE.
REQ-025 pcJump_in==`Jump SHALL take priority over every other event: pc <= pcTarget_in, state -> IDLE, counters cleared, instE_out cleared.
REQ-026 A byte returning the cycle after a jump-aborted grant SHALL be discarded and SHALL NOT write the icache.
REQ-027 A jump in the same cycle as the 4th byte return SHALL suppress that icache write and offer.
REQ-028 pc arithmetic SHALL be 32-bit modulo; pc+4 from 32'hFFFFFFFC wraps to 0.
REQ-029 Icache index = pc[log2(ICACHE_LINES)+1:2], tag = remaining upper bits; pc[1:0] is ignored.
REQ-030 rdy_in==0 SHALL freeze state, counters, pc, outputs and icache; memRe_out SHALL be 0 while frozen.

Reset
REQ-031 On rst_in==0, asynchronously: pc=RESET_PC, state=IDLE, counters=0, memRe_out=0, memAddr_out=0, stallReq_out=0, instE_out=0, pc_out=`ZERO32, inst_out=`ZERO32, all icache valid bits=0.
REQ-032 Reset asserted mid-FETCH SHALL abandon the fetch; no icache write for it.

Structure
REQ-033 State encoding, `stallRange, `addrRange, `instRange, `Jump/`Stall constants SHALL live in the shared defines package.
REQ-034 The icache SHALL be a sub-module named icache (combinational read, synchronous write, async valid clear).

Verification
REQ-035 Cold fetch: reset, RESET_PC=0, memory bytes 13,05,A0,00, grant always 1 -> memAddr 0,1,2,3; instE_out=1 with inst_out=32'h00A00513, pc_out=0.
REQ-036 Grant stall: grant low cycles 2-3 -> memAddr_out held at 1, final word unchanged, stallReq_out high throughout FETCH.
REQ-037 Hit: re-jump to 0 after first fetch -> instE_out=1 one cycle after IDLE, memRe_out never asserted.
REQ-038 Jump mid-fetch: pcJump_in=1, pcTarget_in=32'h100 after 2 grants -> next memAddr_out=32'h100, stale byte discarded, icache index 0 unchanged.
REQ-039 Offer hold: stall_in[1]=1 for 3 cycles in OFFER -> outputs stable, pc advances to 4 only after stall release.
REQ-040 Async reset asserted mid-FETCH -> all outputs zero immediately, refetch from RESET_PC after release.
